// File: rtl/fib_pkg.sv
// Shared types and widths for the Fibonacci generator/checker pair.
package fib_pkg;

  localparam int FIB_W = 32;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_SEED0,
    ST_SEED1,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } fib_chk_state_t;

endpackage

// File: rtl/fib_stream_checker.sv
// Checks a Fibonacci term stream against F(k) = F(k-1) + F(k-2) mod 2^32 and
// reports the count of good terms, completion, and the first mismatch.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int               N     = 10,
  parameter logic [FIB_W-1:0] SEED0 = 32'd0,
  parameter logic [FIB_W-1:0] SEED1 = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [FIB_W-1:0] in_data,
  output logic [CNT_W-1:0] term_count,
  output logic [FIB_W-1:0] expected,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] err_index,
  output logic [FIB_W-1:0] err_actual,
  output logic             overflow
);

  if (N < 2 || N > 65535) begin : g_bad_n
    $error("fib_stream_checker: N must be in 2..65535");
  end

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  fib_chk_state_t   state, state_d;
  logic [FIB_W-1:0] prev1, prev2, prev1_d, prev2_d;
  logic [CNT_W-1:0] term_count_d, err_index_d;
  logic [FIB_W-1:0] expected_d, err_actual_d;
  logic             done_d, error_d, overflow_d;
  logic [FIB_W:0]   sum;

  // The accepted beat becomes the new prev1 and the old prev1 the new prev2,
  // so the next requirement is simply in_data + prev1, carry included.
  assign sum = {1'b0, in_data} + {1'b0, prev1};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d      = state;
    term_count_d = term_count;
    expected_d   = expected;
    done_d       = done;
    error_d      = error;
    err_index_d  = err_index;
    err_actual_d = err_actual;
    overflow_d   = overflow;
    prev1_d      = prev1;
    prev2_d      = prev2;

    if (clear) begin
      state_d      = ST_SEED0;
      term_count_d = '0;
      expected_d   = SEED0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      err_index_d  = '0;
      err_actual_d = '0;
      overflow_d   = 1'b0;
      prev1_d      = '0;
      prev2_d      = '0;
    end else if (in_valid && state inside {ST_SEED0, ST_SEED1, ST_CHECK}) begin
      if (in_data == expected) begin
        term_count_d = term_count + CNT_W'(1);
        prev2_d      = prev1;
        prev1_d      = in_data;
        if (state == ST_SEED0) begin
          expected_d = SEED1;
          state_d    = ST_SEED1;
        end else begin
          expected_d = sum[FIB_W-1:0];
          if (sum[FIB_W]) overflow_d = 1'b1;
          if (term_count_d == N_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (state == ST_SEED1) begin
            state_d = ST_CHECK;
          end
        end
      end else begin
        // expected deliberately holds so the required value stays visible.
        state_d      = ST_ERROR;
        error_d      = 1'b1;
        err_index_d  = term_count;
        err_actual_d = in_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_SEED0;
      term_count <= '0;
      expected   <= SEED0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
      err_actual <= '0;
      overflow   <= 1'b0;
      prev1      <= '0;
      prev2      <= '0;
    end else begin
      state      <= state_d;
      term_count <= term_count_d;
      expected   <= expected_d;
      done       <= done_d;
      error      <= error_d;
      err_index  <= err_index_d;
      err_actual <= err_actual_d;
      overflow   <= overflow_d;
      prev1      <= prev1_d;
      prev2      <= prev2_d;
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
// Directed bench for fib_stream_checker: vector tables plus hand-written
// sequences for clear, gaps, wrap-around, N=2 and asynchronous reset.
module tb_fib_stream_checker;
  import fib_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid;
  logic [31:0] in_data;

  logic [15:0] tc10, ei10, tc50, ei50, tc2, ei2;
  logic [31:0] ex10, ea10, ex50, ea50, ex2, ea2;
  logic        dn10, er10, ov10, dn50, er50, ov50, dn2, er2, ov2;

  fib_stream_checker #(.N(10)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .term_count(tc10), .expected(ex10), .done(dn10), .error(er10),
    .err_index(ei10), .err_actual(ea10), .overflow(ov10));

  fib_stream_checker #(.N(50)) dut50 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .term_count(tc50), .expected(ex50), .done(dn50), .error(er50),
    .err_index(ei50), .err_actual(ea50), .overflow(ov50));

  fib_stream_checker #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .term_count(tc2), .expected(ex2), .done(dn2), .error(er2),
    .err_index(ei2), .err_actual(ea2), .overflow(ov2));

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [15:0] count;
    logic [31:0] expv;
    logic        done;
    logic        error;
  } vec_t;

  vec_t s1[10];
  vec_t s2[7];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic beat(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    check({tag, ".term_count"}, 32'(tc10), 32'(v.count));
    check({tag, ".expected"},   ex10,      v.expv);
    check({tag, ".done"},       32'(dn10), 32'(v.done));
    check({tag, ".error"},      32'(er10), 32'(v.error));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},      32'(dut.state), 32'(ST_SEED0));
    check({tag, ".term_count"}, 32'(tc10), 32'd0);
    check({tag, ".expected"},   ex10,      32'd0);
    check({tag, ".done"},       32'(dn10), 32'd0);
    check({tag, ".error"},      32'(er10), 32'd0);
    check({tag, ".overflow"},   32'(ov10), 32'd0);
    check({tag, ".err_index"},  32'(ei10), 32'd0);
    check({tag, ".err_actual"}, ea10,      32'd0);
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic run_s1(input string tag);
    for (int i = 0; i < 10; i++) begin
      beat(s1[i].valid, s1[i].data);
      check_vec(s1[i], $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        valid  data    count  expected done  error
    s1[0] = '{1'b1, 32'd0,  16'd1,  32'd1,  1'b0, 1'b0};
    s1[1] = '{1'b1, 32'd1,  16'd2,  32'd1,  1'b0, 1'b0};
    s1[2] = '{1'b1, 32'd1,  16'd3,  32'd2,  1'b0, 1'b0};
    s1[3] = '{1'b1, 32'd2,  16'd4,  32'd3,  1'b0, 1'b0};
    s1[4] = '{1'b1, 32'd3,  16'd5,  32'd5,  1'b0, 1'b0};
    s1[5] = '{1'b1, 32'd5,  16'd6,  32'd8,  1'b0, 1'b0};
    s1[6] = '{1'b1, 32'd8,  16'd7,  32'd13, 1'b0, 1'b0};
    s1[7] = '{1'b1, 32'd13, 16'd8,  32'd21, 1'b0, 1'b0};
    s1[8] = '{1'b1, 32'd21, 16'd9,  32'd34, 1'b0, 1'b0};
    s1[9] = '{1'b1, 32'd34, 16'd10, 32'd55, 1'b1, 1'b0};

    s2[0] = '{1'b1, 32'd0,  16'd1,  32'd1,  1'b0, 1'b0};
    s2[1] = '{1'b1, 32'd1,  16'd2,  32'd1,  1'b0, 1'b0};
    s2[2] = '{1'b1, 32'd1,  16'd3,  32'd2,  1'b0, 1'b0};
    s2[3] = '{1'b1, 32'd2,  16'd4,  32'd3,  1'b0, 1'b0};
    s2[4] = '{1'b1, 32'd4,  16'd4,  32'd3,  1'b0, 1'b1};
    s2[5] = '{1'b1, 32'd3,  16'd4,  32'd3,  1'b0, 1'b1};
    s2[6] = '{1'b1, 32'd5,  16'd4,  32'd3,  1'b0, 1'b1};

    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    check_reset_vals("reset");
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: clean ten-term run, N=10; N=2 instance finishes early and holds.
    run_s1("s1");
    check("s1.overflow", 32'(ov10), 32'd0);
    check("n2.done",       32'(dn2), 32'd1);
    check("n2.term_count", 32'(tc2), 32'd2);
    check("n2.expected",   ex2,      32'd1);
    check("n2.error",      32'(er2), 32'd0);
    check("n2.state",      32'(dut2.state), 32'(ST_DONE));

    // Scenario 2: mismatch at index 4, later beats ignored.
    do_clear();
    for (int i = 0; i < 7; i++) begin
      beat(s2[i].valid, s2[i].data);
      check_vec(s2[i], $sformatf("s2[%0d]", i));
    end
    check("s2.err_index",  32'(ei10), 32'd4);
    check("s2.err_actual", ea10,      32'd4);

    // Scenario 5: clear and a beat together; clear wins, beat dropped.
    in_valid = 1'b1;
    in_data  = 32'd0;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check_reset_vals("s5");
    run_s1("s5");

    // Scenario 4: idle cycles between beats change nothing.
    do_clear();
    for (int i = 0; i < 10; i++) begin
      beat(s1[i].valid, s1[i].data);
      check_vec(s1[i], $sformatf("s4[%0d]", i));
      beat(1'b0, 32'hdead_beef);
      check_vec(s1[i], $sformatf("s4gap[%0d]", i));
    end

    // Scenario 3: N=50 through the 32-bit wrap; F(48) is the first wrapped term.
    do_clear();
    begin
      logic [31:0] a, b, t;
      a = 32'd0;
      b = 32'd1;
      for (int k = 0; k < 50; k++) begin
        beat(1'b1, a);
        check($sformatf("s3.overflow[%0d]", k), 32'(ov50), (k >= 47) ? 32'd1 : 32'd0);
        if (k == 47) check("s3.expected_f48", ex50, 32'd512559680);
        t = a + b;
        a = b;
        b = t;
      end
      check("s3.done",       32'(dn50), 32'd1);
      check("s3.error",      32'(er50), 32'd0);
      check("s3.term_count", 32'(tc50), 32'd50);
      check("s3.expected",   ex50,      a);
    end

    // Scenario 6: asynchronous reset between edges mid-run.
    do_clear();
    for (int i = 0; i < 6; i++) beat(1'b1, s1[i].data);
    check("s6.pre_count", 32'(tc10), 32'd6);
    #3 reset = 1'b0;
    #1;
    check_reset_vals("s6");
    check("s6.n50_count", 32'(tc50), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    run_s1("s6run");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
